uart_host_command_issuer: RTL and testbench

UART_HOST_COMMAND_ISSUER -- requirements
Module: uart_host_command_issuer

---
 rtl/uart_host_command_issuer_pkg.sv | 36 +++
 rtl/uart_host_command_issuer_word_serializer.sv | 36 +++
 rtl/uart_host_command_issuer.sv | 163 ++++++++++++++++
 tb/tb_uart_host_command_issuer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_command_issuer_pkg.sv
// Shared definitions for the UART host command issuer: device-id width, command
// encodings, header field positions and the issuer FSM state type.
package uart_host_command_issuer_pkg;

    localparam int UART_DEV_ADDR_SZ = 4;

    localparam logic UART_READ  = 1'b0;
    localparam logic UART_WRITE = 1'b1;

    localparam int HDR_WRITE_BIT = 31;
    localparam int HDR_DEV_LSB   = 24;
    localparam int HDR_ADDR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_HDR  = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_RSP  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Bits 30:28 and 23:16 stay zero.
    function automatic logic [31:0] make_header(
        input logic                        write,
        input logic [UART_DEV_ADDR_SZ-1:0] dev,
        input logic [15:0]                 addr
    );
        logic [31:0] h;
        h = '0;
        h[HDR_WRITE_BIT]                        = write;
        h[HDR_DEV_LSB +: UART_DEV_ADDR_SZ]      = dev;
        h[HDR_ADDR_LSB +: 16]                   = addr;
        return h;
    endfunction

endpackage

// File: rtl/uart_host_command_issuer_word_serializer.sv
// Shifts a 32-bit word out MSB byte first over a valid/ready byte stream.
// A byte moves when valid & ready; the byte stays stable while valid & !ready.
module UartWordSerializer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        last,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  tx_byte
);

    logic [31:0] shreg;
    logic        valid_q;

    // A load wins over the final shift so back-to-back words leave no gap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg   <= word;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            shreg <= {shreg[23:0], 8'h00};
            if (last) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid   = valid_q;
    assign tx_byte = shreg[31:24];

endmodule

// File: rtl/uart_host_command_issuer.sv
// Issues one header (+ write data) command over a byte stream and collects the
// 4-byte response. Optional response timeout: define UART_HOST_TIMEOUT_EN.
module uart_host_command_issuer
    import uart_host_command_issuer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic                        iCmdValid,
    output logic                        oCmdReady,
    input  logic                        iCmdWrite,
    input  logic [UART_DEV_ADDR_SZ-1:0] iCmdDevAddr,
    input  logic [15:0]                 iCmdMemAddr,
    input  logic [31:0]                 iCmdData,
    output logic                        oTxByteValid,
    output logic [7:0]                  oTxByte,
    input  logic                        iTxByteReady,
    input  logic                        iRxByteValid,
    input  logic [7:0]                  iRxByte,
    output logic                        oRspValid,
    output logic [31:0]                 oRspData,
    output logic                        oBusy,
    output logic                        oTimeout
);

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        is_write_q;
    logic [31:0] data_q;
    logic [31:0] rsp_shift;
    logic [31:0] rsp_q;
    logic        tx_fire;
    logic        rx_take;
    logic        ser_load;
    logic [31:0] ser_word;
    logic        ser_valid;
    logic [7:0]  ser_byte;
    logic        timeout_hit;

    assign tx_fire = ser_valid && iTxByteReady;
    assign rx_take = (state == ST_WAIT_RSP) && iRxByteValid;

`ifdef UART_HOST_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Held at zero outside WAIT_RSP, so every entry into WAIT_RSP starts fresh.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            idle_cnt <= 32'h0;
        end else if ((state != ST_WAIT_RSP) || iRxByteValid) begin
            idle_cnt <= 32'h0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout_hit = (state == ST_WAIT_RSP) && !iRxByteValid &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ser_load  = 1'b0;
        ser_word  = data_q;
        case (state)
            ST_IDLE: begin
                if (iCmdValid) begin
                    ser_load  = 1'b1;
                    ser_word  = make_header(iCmdWrite, iCmdDevAddr, iCmdMemAddr);
                    cnt_nxt   = 2'd0;
                    state_nxt = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (tx_fire) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        if (is_write_q == UART_WRITE) begin
                            ser_load  = 1'b1;
                            state_nxt = ST_SEND_DATA;
                        end else begin
                            state_nxt = ST_WAIT_RSP;
                        end
                    end
                end
            end
            ST_SEND_DATA: begin
                if (tx_fire) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_nxt = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (timeout_hit) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = ST_IDLE;
                end else if (iRxByteValid) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state      <= ST_IDLE;
            cnt        <= 2'd0;
            is_write_q <= 1'b0;
            data_q     <= 32'h0;
            rsp_shift  <= 32'h0;
            rsp_q      <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((state == ST_IDLE) && iCmdValid) begin
                is_write_q <= iCmdWrite;
                data_q     <= iCmdData;
            end
            if (rx_take) begin
                rsp_shift <= {rsp_shift[23:0], iRxByte};
                if (cnt == 2'd3) begin
                    rsp_q <= {rsp_shift[23:0], iRxByte};
                end
            end
        end
    end

    UartWordSerializer u_serializer (
        .clk     (iClock),
        .reset_n (iReset),
        .load    (ser_load),
        .word    (ser_word),
        .last    (cnt == 2'd3),
        .ready   (iTxByteReady),
        .valid   (ser_valid),
        .tx_byte (ser_byte)
    );

    // Outputs are forced to their idle values while reset is held low.
    assign oCmdReady    = (state == ST_IDLE) || !iReset;
    assign oBusy        = !oCmdReady;
    assign oTxByteValid = ser_valid && iReset;
    assign oTxByte      = iReset ? ser_byte : 8'h00;
    assign oRspValid    = (state == ST_DONE) && iReset;
    assign oRspData     = iReset ? rsp_q : 32'h0;
    assign oTimeout     = timeout_hit && iReset;

endmodule

// File: tb/tb_uart_host_command_issuer.sv
// Bench for uart_host_command_issuer: directed and random commands checked
// against a byte-level model of the header/data stream and response packing.
module tb_uart_host_command_issuer;

    logic        clk = 1'b0;
    logic        iReset;
    logic        iCmdValid;
    logic        oCmdReady;
    logic        iCmdWrite;
    logic [3:0]  iCmdDevAddr;
    logic [15:0] iCmdMemAddr;
    logic [31:0] iCmdData;
    logic        oTxByteValid;
    logic [7:0]  oTxByte;
    logic        iTxByteReady;
    logic        iRxByteValid;
    logic [7:0]  iRxByte;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oBusy;
    logic        oTimeout;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] last_rsp = 32'h0;

    always #5 clk = ~clk;

    uart_host_command_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .iClock       (clk),
        .iReset       (iReset),
        .iCmdValid    (iCmdValid),
        .oCmdReady    (oCmdReady),
        .iCmdWrite    (iCmdWrite),
        .iCmdDevAddr  (iCmdDevAddr),
        .iCmdMemAddr  (iCmdMemAddr),
        .iCmdData     (iCmdData),
        .oTxByteValid (oTxByteValid),
        .oTxByte      (oTxByte),
        .iTxByteReady (iTxByteReady),
        .iRxByteValid (iRxByteValid),
        .iRxByte      (iRxByte),
        .oRspValid    (oRspValid),
        .oRspData     (oRspData),
        .oBusy        (oBusy),
        .oTimeout     (oTimeout)
    );

    // Reference header: write flag on bit 31, device id on bits 27:24, address low half.
    function automatic logic [31:0] model_header(input logic w, input logic [3:0] d, input logic [15:0] a);
        return (32'(w) << 31) | (32'(d) << 24) | 32'(a);
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] word, input int idx);
        return 8'(word >> (24 - 8 * idx));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iCmdValid    = 1'b0;
        iCmdWrite    = 1'b0;
        iCmdDevAddr  = 4'h0;
        iCmdMemAddr  = 16'h0;
        iCmdData     = 32'h0;
        iTxByteReady = 1'b0;
        iRxByteValid = 1'b0;
        iRxByte      = 8'h00;
    endtask

    // mode: 0 = ready always high, 1 = ready toggling starting low, 2 = random ready.
    task automatic do_cmd(input logic w, input logic [3:0] d, input logic [15:0] a,
                          input logic [31:0] data, input int mode, input logic [31:0] rsp,
                          input bit junk_rx, input bit hold_valid);
        logic [31:0] hdr;
        logic [7:0]  held_byte;
        logic [7:0]  exp_b;
        bit          held;
        int          accepts;
        int          cyc;
        hdr = model_header(w, d, a);
        for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(hdr, i));
        if (w) for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(data, i));

        iCmdValid = 1'b1; iCmdWrite = w; iCmdDevAddr = d; iCmdMemAddr = a; iCmdData = data;
        @(negedge clk);
        vectors++;
        if (oCmdReady !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: got %b want 1", oCmdReady);
        end
        accepts = (iCmdValid && oCmdReady) ? 1 : 0;
        step();
        if (!hold_valid) iCmdValid = 1'b0;
        iCmdWrite = 1'($urandom); iCmdDevAddr = 4'($urandom); iCmdMemAddr = 16'($urandom);
        iCmdData = $urandom;

        held = 1'b0; held_byte = 8'h00; cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (mode == 0) iTxByteReady = 1'b1;
            else if (mode == 1) iTxByteReady = (cyc % 2 == 1);
            else iTxByteReady = 1'($urandom_range(0, 1));
            if (junk_rx && cyc < 2) begin
                iRxByteValid = 1'b1;
                iRxByte = (cyc == 0) ? 8'hAA : 8'h55;
            end else begin
                iRxByteValid = 1'b0;
            end
            @(negedge clk);
            if (hold_valid) begin
                accepts += (iCmdValid && oCmdReady) ? 1 : 0;
                vectors++;
                if (oBusy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_tx: got %b want 1 (cycle %0d)", oBusy, cyc);
                end
            end
            if (mode == 0) begin
                vectors++;
                if (oTxByteValid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tx_gap: valid %b want 1 (cycle %0d)", oTxByteValid, cyc);
                end
            end
            if (held) begin
                vectors++;
                if (oTxByteValid !== 1'b1 || oTxByte !== held_byte) begin
                    miscompares++;
                    $display("FAIL tx_hold: valid %b byte %h want 1 %h", oTxByteValid, oTxByte, held_byte);
                end
            end
            if (oTxByteValid === 1'b1 && iTxByteReady) begin
                exp_b = exp_q.pop_front();
                vectors++;
                if (oTxByte !== exp_b) begin
                    miscompares++;
                    $display("FAIL tx_byte: got %h want %h", oTxByte, exp_b);
                end
            end
            held = (oTxByteValid === 1'b1) && !iTxByteReady;
            held_byte = oTxByte;
            step();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_timeout: %0d bytes missing want 0", exp_q.size());
            exp_q.delete();
        end
        iTxByteReady = 1'b0;
        iRxByteValid = 1'b0;

        @(negedge clk);
        vectors++;
        if (oTxByteValid !== 1'b0 || oBusy !== 1'b1 || oRspValid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_rsp: txv %b busy %b rspv %b want 0 1 0", oTxByteValid, oBusy, oRspValid);
        end
        if (hold_valid) accepts += (iCmdValid && oCmdReady) ? 1 : 0;
        step();

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
                iRxByteValid = 1'b0;
                iRxByte = 8'($urandom);
                @(negedge clk);
                vectors++;
                if (oRspValid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rsp_early: got %b want 0", oRspValid);
                end
                if (hold_valid) accepts += (iCmdValid && oCmdReady) ? 1 : 0;
                step();
            end
            iRxByteValid = 1'b1;
            iRxByte = byte_of(rsp, i);
            @(negedge clk);
            if (hold_valid) accepts += (iCmdValid && oCmdReady) ? 1 : 0;
            step();
        end
        iRxByteValid = 1'b0;

        @(negedge clk);
        vectors++;
        if (oRspValid !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_valid: got %b want 1", oRspValid);
        end
        vectors++;
        if (oRspData !== rsp) begin
            miscompares++;
            $display("FAIL rsp_data: got %h want %h", oRspData, rsp);
        end
        vectors++;
        if (oBusy !== 1'b1 || oTimeout !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_done: busy %b timeout %b want 1 0", oBusy, oTimeout);
        end
        if (hold_valid) accepts += (iCmdValid && oCmdReady) ? 1 : 0;
        step();
        iCmdValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (oRspValid !== 1'b0 || oCmdReady !== 1'b1 || oRspData !== rsp) begin
            miscompares++;
            $display("FAIL post_done: rspv %b ready %b data %h want 0 1 %h", oRspValid, oCmdReady, oRspData, rsp);
        end
        if (hold_valid) begin
            vectors++;
            if (accepts != 1) begin
                miscompares++;
                $display("FAIL accept_count: got %0d want 1", accepts);
            end
        end
        last_rsp = rsp;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        iReset = 1'b0;
        iCmdValid = 1'b1;
        iCmdWrite = 1'b1;
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (oCmdReady !== 1'b1 || oBusy !== 1'b0 || oTxByteValid !== 1'b0 ||
                oRspValid !== 1'b0 || oTimeout !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: ready %b busy %b txv %b rspv %b to %b want 1 0 0 0 0",
                         oCmdReady, oBusy, oTxByteValid, oRspValid, oTimeout);
            end
            vectors++;
            if (oTxByte !== 8'h00 || oRspData !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_data: txbyte %h rsp %h want 00 00000000", oTxByte, oRspData);
            end
            step();
        end
        idle_inputs();
        iReset = 1'b1;
        @(negedge clk);
        vectors++;
        if (oCmdReady !== 1'b1 || oTxByteValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready %b txv %b want 1 0", oCmdReady, oTxByteValid);
        end
        step();
    endtask

    task automatic test_directed_write();
        do_cmd(1'b1, 4'hC, 16'h0010, 32'hDEADBEEF, 0, 32'h00000001, 1'b0, 1'b0);
    endtask

    task automatic test_directed_read();
        do_cmd(1'b0, 4'hD, 16'h0003, 32'h0, 1, 32'h12345678, 1'b0, 1'b0);
    endtask

    task automatic test_rx_during_hdr();
        do_cmd(1'b0, 4'h5, 16'hBEEF, 32'h0, 0, 32'h00000002, 1'b1, 1'b0);
    endtask

    task automatic test_hold_valid();
        do_cmd(1'b1, 4'h3, 16'h1234, 32'hCAFEF00D, 2, 32'hA5A5_0F0F, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_data();
        iCmdValid = 1'b1; iCmdWrite = 1'b1; iCmdDevAddr = 4'h9; iCmdMemAddr = 16'h4242;
        iCmdData = 32'h01234567; iTxByteReady = 1'b1;
        @(negedge clk);
        step();
        iCmdValid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            step();
        end
        iReset = 1'b0;
        @(negedge clk);
        vectors++;
        if (oTxByteValid !== 1'b0 || oCmdReady !== 1'b1 || oRspValid !== 1'b0 || oTxByte !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: txv %b ready %b rspv %b byte %h want 0 1 0 00",
                     oTxByteValid, oCmdReady, oRspValid, oTxByte);
        end
        step();
        iReset = 1'b1;
        iTxByteReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iRxByteValid = (i < 4);
            iRxByte = 8'($urandom);
            @(negedge clk);
            vectors++;
            if (oRspValid !== 1'b0 || oCmdReady !== 1'b1 || oTxByteValid !== 1'b0 || oRspData !== 32'h0) begin
                miscompares++;
                $display("FAIL after_reset: rspv %b ready %b txv %b data %h want 0 1 0 00000000",
                         oRspValid, oCmdReady, oTxByteValid, oRspData);
            end
            step();
        end
        iRxByteValid = 1'b0;
        last_rsp = 32'h0;
    endtask

`ifdef UART_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        iCmdValid = 1'b1; iCmdWrite = 1'b0; iCmdDevAddr = 4'h1; iCmdMemAddr = 16'h0007;
        iTxByteReady = 1'b1;
        @(negedge clk);
        step();
        iCmdValid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            step();
        end
        iTxByteReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iRxByteValid = 1'b1;
            iRxByte = 8'(i + 1);
            @(negedge clk);
            step();
        end
        iRxByteValid = 1'b0;
        seen = 0;
        for (int j = 1; j <= 40 && seen == 0; j++) begin
            @(negedge clk);
            if (oTimeout === 1'b1) begin
                seen = j;
                vectors++;
                if (oRspValid !== 1'b0 || oRspData !== last_rsp) begin
                    miscompares++;
                    $display("FAIL timeout_rsp: rspv %b data %h want 0 %h", oRspValid, oRspData, last_rsp);
                end
            end
            step();
        end
        vectors++;
        if (seen != 17) begin
            miscompares++;
            $display("FAIL timeout_cycle: pulse in cycle %0d want 17", seen);
        end
        @(negedge clk);
        vectors++;
        if (oCmdReady !== 1'b1 || oTimeout !== 1'b0 || oRspData !== last_rsp) begin
            miscompares++;
            $display("FAIL timeout_idle: ready %b to %b data %h want 1 0 %h", oCmdReady, oTimeout, oRspData, last_rsp);
        end
        step();
    endtask
`endif

    task automatic test_random();
        logic        w;
        logic [31:0] rsp;
        for (int n = 0; n < 20; n++) begin
            w = 1'($urandom);
            rsp = $urandom;
            do_cmd(w, 4'($urandom), 16'($urandom), $urandom, $urandom_range(0, 2), rsp,
                   1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached want completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed_write();
        test_directed_read();
        test_rx_during_hdr();
        test_hold_valid();
        test_reset_mid_data();
`ifdef UART_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
